// File: rtl/pitch_pkg.sv
// pitch_pkg: shared widths, semitone limits, ratio LUT and FSM states
// for the pitch_shift_resampler slice.
package pitch_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int FRAC_W_DEF   = 12;
  localparam int SEMI_MAX     = 12;
  localparam int SEMI_MIN     = -12;
  localparam int RATIO_W      = 14;

  // round(4096 * 2^(n/12)) for n = -12..+12, indexed by n+12
  localparam logic [RATIO_W-1:0] RATIO_LUT [25] = '{
    14'd2048, 14'd2170, 14'd2299, 14'd2435, 14'd2580,
    14'd2734, 14'd2896, 14'd3069, 14'd3251, 14'd3444,
    14'd3649, 14'd3866, 14'd4096, 14'd4340, 14'd4598,
    14'd4871, 14'd5161, 14'd5468, 14'd5793, 14'd6137,
    14'd6502, 14'd6889, 14'd7298, 14'd7732, 14'd8192
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_CALC,
    S_OUT
  } state_e;

  // Saturate the signed shift to +-12 and turn it into a LUT index
  function automatic logic [4:0] semi_idx(input logic [7:0] amt);
    int n;
    n = int'($signed(amt));
    if (n > SEMI_MAX) n = SEMI_MAX;
    if (n < SEMI_MIN) n = SEMI_MIN;
    return 5'(n - SEMI_MIN);
  endfunction

endpackage

// File: rtl/sample_ring_ram.sv
// sample_ring_ram: DEPTH x W simple dual-port RAM,
// synchronous read (old data on same-address collision).
module sample_ring_ram #(
  parameter  int DEPTH = 1024,
  parameter  int W     = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];

  // One write port, one registered read port
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/pitch_shift_resampler.sv
// pitch_shift_resampler: ring-buffer pitch shifter, one output per input.
// PITCH_INTERP_EN: linear interpolation; undefined: nearest sample.
module pitch_shift_resampler
  import pitch_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          shift_amt,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_in_valid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid,
  output logic                overrun,
  output logic                retarget
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + FRAC_W;
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(DEPTH / 2);
  localparam logic [ADDR_W-1:0] LO   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] HI   = ADDR_W'(DEPTH - 4);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   mute_q;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [RATIO_W-1:0]  ratio_q;
  logic signed [SAMPLE_W-1:0] s0_q, s1, y;
  logic [SAMPLE_W-1:0] out_q, out_d;
  logic [SAMPLE_W-1:0] rdata;
  logic vld_q, vld_d;
  logic ovr_q, ovr_d;
  logic ret_q, ret_d;

  logic [ADDR_W-1:0] rd_int, raddr;
  logic [ADDR_W-1:0] adv_int, gap;
  logic [PW-1:0]     rd_adv;
  logic              near;

  assign rd_int = rd_ptr_q[PW-1:FRAC_W];
  assign raddr  = (state_q == S_RD1) ? rd_int + ADDR_W'(1) : rd_int;

  sample_ring_ram #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (sample_in_valid),
    .waddr_i (wr_ptr_q),
    .wdata_i (sample_in),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign s1 = rdata;

`ifdef PITCH_INTERP_EN
  localparam int PRW = SAMPLE_W + 1 + FRAC_W;
  logic signed [SAMPLE_W:0] diff;
  logic signed [PRW-1:0]    prod;
  logic                     unused_prod;

  assign diff = $signed({s1[SAMPLE_W-1], s1})
              - $signed({s0_q[SAMPLE_W-1], s0_q});
  assign prod = PRW'(diff)
              * $signed(PRW'(rd_ptr_q[FRAC_W-1:0]));
  // Result is bounded by s0..s1, so the low slice of the floor-shift suffices
  assign y = s0_q + prod[FRAC_W +: SAMPLE_W];
  assign unused_prod = ^{prod[PRW-1:FRAC_W+SAMPLE_W],
                         prod[FRAC_W-1:0]};
`else
  assign y = rd_ptr_q[FRAC_W-1] ? s1 : s0_q;
`endif

  assign rd_adv  = rd_ptr_q + PW'(ratio_q);
  assign adv_int = rd_adv[PW-1:FRAC_W];
  assign gap     = wr_ptr_q - adv_int;
  assign near    = (gap < LO) || (gap > HI);

  // Sequencer: next state, pointer advance/recentre, output values
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    out_d    = out_q;
    vld_d    = 1'b0;
    ret_d    = 1'b0;
    ovr_d    = ovr_q | (sample_in_valid & (state_q != S_IDLE));
    unique case (state_q)
      S_IDLE: if (sample_in_valid) state_d = S_RD0;
      S_RD0:  state_d = S_RD1;
      S_RD1:  state_d = S_CALC;
      S_CALC: begin
        state_d  = S_OUT;
        vld_d    = 1'b1;
        ret_d    = near;
        out_d    = (mute_q < HALF) ? '0 : y;
        rd_ptr_d = near ? {wr_ptr_q - HALF, rd_adv[FRAC_W-1:0]}
                        : rd_adv;
      end
      S_OUT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, read pointer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= {HALF, {FRAC_W{1'b0}}};
      out_q    <= '0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ret_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      ovr_q    <= ovr_d;
      ret_q    <= ret_d;
    end
  end

  // Write side: every strobe lands, busy or not; warm-up count saturates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      mute_q   <= '0;
    end else if (sample_in_valid) begin
      wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (mute_q != HALF) mute_q <= mute_q + ADDR_W'(1);
    end
  end

  // Ratio sampled only on accept, so shift changes never land mid-sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ratio_q <= '0;
    end else if (state_q == S_IDLE && sample_in_valid) begin
      ratio_q <= RATIO_LUT[semi_idx(shift_amt)];
    end
  end

  // Left neighbour captured as its read data returns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_q <= '0;
    end else if (state_q == S_RD1) begin
      s0_q <= rdata;
    end
  end

  assign sample_out       = out_q;
  assign sample_out_valid = vld_q;
  assign overrun          = ovr_q;
  assign retarget         = ret_q;

endmodule

// File: tb/tb_pitch_shift_resampler.sv
// tb_pitch_shift_resampler: directed stimulus against a behavioural
// ring-buffer model, checked every cycle, plus literal pins.
module tb_pitch_shift_resampler;

  localparam int DEPTH = 1024;
  localparam int HALF  = 512;
  localparam int FW    = 12;
  localparam int FONE  = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  shift_amt = '0;
  logic [15:0] sample_in = '0;
  logic        sample_in_valid = 1'b0;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic        overrun;
  logic        retarget;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int n_vld = 0;
  int n_ret = 0;
  int last_out = 0;

  always #5 clk = ~clk;

  pitch_shift_resampler dut (
    .clk              (clk),
    .reset            (reset),
    .shift_amt        (shift_amt),
    .sample_in        (sample_in),
    .sample_in_valid  (sample_in_valid),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .overrun          (overrun),
    .retarget         (retarget)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Ratio straight from the definition 2^(n/12), rounded
  function automatic int ratio_of(input logic [7:0] amt);
    int n;
    real r;
    n = int'($signed(amt));
    if (n > 12) n = 12;
    if (n < -12) n = -12;
    r = 4096.0 * $pow(2.0, n / 12.0);
    return $rtoi(r + 0.5);
  endfunction

  function automatic int interp(input int s0, input int s1, input int fr);
`ifdef PITCH_INTERP_EN
    int p;
    p = (s1 - s0) * fr;
    return s0 + (p >>> FW);
`else
    return (fr >= FONE / 2) ? s1 : s0;
`endif
  endfunction

  int m_buf [DEPTH];
  bit m_wrt [DEPTH];
  int m_wr, m_rd, m_cnt, m_age, m_ratio;
  int e_out, e_vld, e_ret, e_ovr, e_chk;

  function automatic int m_y();
    int ri;
    ri = m_rd / FONE;
    if (m_cnt < HALF) return 0;
    return interp(m_buf[ri], m_buf[(ri + 1) % DEPTH], m_rd % FONE);
  endfunction

  function automatic int m_known();
    int ri;
    ri = m_rd / FONE;
    if (m_cnt < HALF) return 1;
    return int'(m_wrt[ri] && m_wrt[(ri + 1) % DEPTH]);
  endfunction

  function automatic int m_adv();
    return (m_rd + m_ratio) % (DEPTH * FONE);
  endfunction

  function automatic int m_near(input int nrd);
    int d;
    d = (m_wr - nrd / FONE + DEPTH) % DEPTH;
    return int'(d < 4 || d > DEPTH - 4);
  endfunction

  function automatic int m_recentre(input int nrd);
    return ((m_wr - HALF + DEPTH) % DEPTH) * FONE + nrd % FONE;
  endfunction

  // Model: age 0 idle, 1..4 = four cycles after an accepted strobe
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_wr <= 0; m_rd <= HALF * FONE; m_cnt <= 0;
      m_age <= 0; m_ratio <= 0;
      e_out <= 0; e_vld <= 0; e_ret <= 0; e_ovr <= 0; e_chk <= 1;
    end else begin
      e_vld <= 0;
      e_ret <= 0;
      if (m_age == 3) begin
        e_out <= m_y();
        e_chk <= m_known();
        e_vld <= 1;
        e_ret <= m_near(m_adv());
        m_rd  <= (m_near(m_adv()) != 0) ? m_recentre(m_adv()) : m_adv();
      end
      if (sample_in_valid) begin
        m_buf[m_wr] <= int'($signed(sample_in));
        m_wrt[m_wr] <= 1'b1;
        m_wr <= (m_wr + 1) % DEPTH;
        if (m_cnt < HALF) m_cnt <= m_cnt + 1;
        if (m_age != 0) e_ovr <= 1;
      end
      if (m_age == 0) begin
        if (sample_in_valid) begin
          m_age <= 1;
          m_ratio <= ratio_of(shift_amt);
        end
      end else begin
        m_age <= (m_age == 4) ? 0 : m_age + 1;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", int'(sample_out_valid), e_vld);
      check("retarget", int'(retarget), e_ret);
      check("overrun", int'(overrun), e_ovr);
      if (e_chk != 0) check("sample_out", int'($signed(sample_out)), e_out);
      if (sample_out_valid) begin
        n_vld++;
        last_out = int'($signed(sample_out));
      end
      if (retarget) n_ret++;
    end
  end

  task automatic send(input int v);
    @(posedge clk); #1;
    sample_in = v[15:0];
    sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #2 reset = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_sample_out", int'(sample_out), 0);
    check("rst_valid", int'(sample_out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_retarget", int'(retarget), 0);

    check("ratio_n0", ratio_of(8'd0), 4096);
    check("ratio_p12", ratio_of(8'd12), 8192);
    check("ratio_m12", ratio_of(8'hF4), 2048);
    check("ratio_p7", ratio_of(8'd7), 6137);
    check("ratio_m5", ratio_of(8'hFB), 3069);
    check("clamp_7f", ratio_of(8'h7F), 8192);
    check("clamp_80", ratio_of(8'h80), 2048);
`ifdef PITCH_INTERP_EN
    check("interp_mid", interp(100, 200, 2048), 150);
    check("interp_floor", interp(0, -1, 1), -1);
`else
    check("nearest_hi", interp(100, 200, 2048), 200);
    check("nearest_lo", interp(100, 200, 2047), 100);
`endif

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    shift_amt = 8'd0;
    for (int k = 1; k <= 600; k++) send(k);
    settle();
    check("unity_delay", last_out, 88);
    check("unity_no_retarget", n_ret, 0);

    shift_amt = 8'd12;
    base = n_ret;
    for (int k = 1; k <= 600; k++)
      send($rtoi(8000.0 * $sin(k * 0.2)));
    settle();
    check("octave_retarget", int'(n_ret > base), 1);

    shift_amt = 8'hF4;
    for (int k = 1; k <= 100; k++) send(((k * 7919) % 60001) - 30000);
    shift_amt = 8'd7;
    for (int k = 1; k <= 100; k++) send(((k * 4099) % 50001) - 25000);
    shift_amt = 8'hFB;
    for (int k = 1; k <= 50; k++) send(((k * 311) % 20001) - 10000);
    shift_amt = 8'h7F;
    for (int k = 1; k <= 40; k++) send(k * 500 - 10000);
    shift_amt = 8'h80;
    for (int k = 1; k <= 40; k++) send(12000 - k * 450);
    shift_amt = 8'd0;
    for (int k = 1; k <= 20; k++) send(k * 100);
    settle();
    check("pre_busy_overrun", int'(overrun), 0);

    base = n_vld;
    @(posedge clk); #1;
    sample_in = 16'd1111; sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    @(posedge clk); #1;
    sample_in = 16'd2222; sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("busy_one_output", n_vld - base, 1);
    check("busy_overrun", int'(overrun), 1);
    for (int k = 1; k <= 10; k++) send(k * 77);
    settle();

    base = n_vld;
    @(posedge clk); #1;
    sample_in = 16'd4321; sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_sample_out", int'(sample_out), 0);
    check("arst_valid", int'(sample_out_valid), 0);
    check("arst_overrun", int'(overrun), 0);
    check("arst_retarget", int'(retarget), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("arst_no_output", n_vld - base, 0);

    shift_amt = 8'd0;
    for (int k = 1; k <= 520; k++) send(3000 + k);
    settle();
    check("arst_rd_ptr_centre", last_out, 3008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pitch_shift_resampler.md
# pitch_shift_resampler

Streaming pitch-shift stage directly downstream of the software interface: consumes its 8-bit `shift_amt` register and applies it to the mono audio sample stream. Incoming samples are written into a circular buffer. A fractional read pointer advances by a semitone-derived ratio and produces one output sample per input sample, using linear interpolation between neighbouring buffer entries. The output feeds the audio codec output path.

## Interface
- `ADDR_W`, 10: log2 of buffer depth; DEPTH = 2^ADDR_W samples.
- `SAMPLE_W`, 16: signed sample width.
- `FRAC_W`, 12: fractional bits of read pointer and ratio.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `shift_amt`  in  8  signed semitone shift (two's complement), from the software interface.
- `sample_in`  in  SAMPLE_W  signed input sample.
- `sample_in_valid`  in  1  one-cycle strobe; `sample_in` is valid.
- `sample_out`  out  SAMPLE_W  signed shifted sample.
- `sample_out_valid`  out  1  one-cycle strobe; `sample_out` is valid.
- `overrun`  out  1  sticky: a strobe arrived while the FSM was busy.
- `retarget`  out  1  one-cycle pulse: the read pointer was re-centred.

## Operation
- Semitone clamp: n = signed `shift_amt` saturated to −12..+12.
- Ratio: R = round(2^FRAC_W · 2^(n/12)), taken from a 25-entry constant LUT.
  - Examples: n=0 → 4096, +12 → 8192, −12 → 2048, +7 → 6137, −5 → 3069.
- Pointers:
  - `wr_ptr` is ADDR_W bits.
  - `rd_ptr` is ADDR_W+FRAC_W bits, split into integer part `rd_int` and fraction `rd_frac`.
  - Both wrap modulo DEPTH without error.
- FSM states: IDLE → RD0 → RD1 → CALC → OUT → IDLE.
  - IDLE: on `sample_in_valid`, write `sample_in` at `wr_ptr`, increment `wr_ptr`, latch R from the current n, go to RD0. R is sampled only here, so a `shift_amt` change takes effect on the next sample and never mid-computation.
  - RD0: read s0 = buf[`rd_int`].
  - RD1: read s1 = buf[`rd_int`+1 mod DEPTH].
  - CALC: y = s0 + ((s1 − s0) · `rd_frac`) >>> FRAC_W.
    - Difference is SAMPLE_W+1 bits; product is SAMPLE_W+1+FRAC_W bits.
    - The shift is arithmetic, so y rounds toward −∞.
    - y always lies between s0 and s1, so no saturation is needed.
  - OUT: drive `sample_out` = y and pulse `sample_out_valid`. Then update `rd_ptr` += R, and apply the collision guard.
- Collision guard: d = (`wr_ptr` − new `rd_int`) mod DEPTH.
  - If d < 4 or d > DEPTH−4: set `rd_int` = `wr_ptr` − DEPTH/2, keep `rd_frac`, and pulse `retarget` in the same cycle as OUT.
- Mute: a counter saturating at DEPTH/2 counts written samples. While the counter is below DEPTH/2, `sample_out` is forced to 0, but valid still pulses.
- Busy strobe: a `sample_in_valid` arriving outside IDLE is still written to the buffer and `wr_ptr` still increments. No extra output is produced, and `overrun` is set.
- Reset values:
  - `wr_ptr` = 0; `rd_ptr` = DEPTH/2 << FRAC_W.
  - FSM = IDLE; mute counter = 0.
  - `sample_out` = 0; `sample_out_valid` = 0; `overrun` = 0; `retarget` = 0.
  - Buffer contents are not reset.
- Reset mid-operation: the FSM returns to IDLE immediately and no partial output is emitted.

## Timing
- Latency: `sample_in_valid` in cycle t → `sample_out_valid` in cycle t+4.
- Minimum strobe spacing without overrun: 5 cycles. At audio rates the spacing is in the thousands of cycles.
- Buffer: synchronous-read RAM with one write port and one read port.
  - Read data returns the cycle after the address, so RD1 captures s0 and CALC captures s1.
  - Same-address write and read in one cycle returns the old data; the guard band makes this unreachable.
- All outputs are registered.

## Configuration
- `PITCH_INTERP_EN` defined: linear interpolation as above.
- Undefined: nearest-sample mode.
  - y = s1 when `rd_frac` ≥ 2^(FRAC_W−1), else s0.
  - The multiplier is removed; FSM states and latency are unchanged.

## Structure
- Package `pitch_pkg`:
  - SAMPLE_W and FRAC_W defaults.
  - Semitone clamp limits ±12.
  - 25-entry ratio LUT as a constant array.
  - FSM state enum.
- Sub-module `sample_ring_ram`: parameterised DEPTH×SAMPLE_W simple dual-port RAM with synchronous read, inferred as block RAM.

## Test plan
- Reset then unity shift: `shift_amt`=0 with a ramp input after DEPTH/2 warm-up samples → output equals the input delayed by DEPTH/2 samples; `retarget` is never asserted.
- Octave up: `shift_amt`=12 → `rd_ptr` advances 2.0 per sample; a 1 kHz sine input yields a 2 kHz output; `retarget` pulses periodically.
- Interpolation: `shift_amt`=−12, buffer entries 100 and 200 with `rd_frac`=2048 → y = 150. With the macro undefined → y = 200.
- Clamp: `shift_amt`=8'h7F → R latched = 8192; `shift_amt`=8'h80 → R = 2048.
- Busy strobe: two `sample_in_valid` strobes 2 cycles apart → one `sample_out_valid`, `overrun`=1, and `wr_ptr` advanced by 2.
- Async reset asserted during CALC → all outputs go to 0 with no clock edge; no `sample_out_valid` is emitted; `rd_ptr` = DEPTH/2<<FRAC_W.
